// File: rtl/rgb_modulate_scheduler.sv
// Round-robin scheduler sharing one 8x8 (a*b)>>8 multiplier among NUM_REQ colour requesters.
// Optional macro RGB_SCHED_WHITE_BYPASS_EN: an all-ones factor skips the multiplier.
//
// state   | meaning
// S_IDLE  | arbitrate, handshake the winner and latch its operands
// S_ISSUE | issue R, G, B to the multiplier on three consecutive cycles
// S_WAIT  | collect outstanding results until all three channels are in
// S_DONE  | one-cycle response pulse
module rgb_modulate_scheduler #(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [NUM_REQ-1:0]    i_req_valid,
    output logic [NUM_REQ-1:0]    o_req_ready,
    input  logic [NUM_REQ*24-1:0] i_req_color,
    input  logic [NUM_REQ*24-1:0] i_req_factor,
    output logic                  o_resp_valid,
    output logic [ID_W-1:0]       o_resp_id,
    output logic [23:0]           o_resp_color,
    output logic                  o_mul_start,
    output logic [7:0]            o_mul_a,
    output logic [7:0]            o_mul_b,
    input  logic [7:0]            i_mul_result,
    input  logic                  i_mul_valid
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t             r_state, w_next;
    logic [ID_W-1:0]    r_ptr, r_id, r_resp_id, w_win, w_idx;
    logic               w_found, w_bypass, w_capture, w_handshake;
    logic [NUM_REQ-1:0] w_grant;
    logic [23:0]        r_color, r_factor, r_res, r_resp_color;
    logic [23:0]        w_win_color, w_win_factor, w_res_next;
    logic [1:0]         r_issue_ch, r_res_ch;
    logic [7:0]         r_mul_a, r_mul_b, w_chan_a, w_chan_b;

    // First pending requester after the pointer, wrapping.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            w_idx = ID_W'((int'(r_ptr) + i) % NUM_REQ);
            if (!w_found && i_req_valid[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    always_comb begin
        w_win_color  = '0;
        w_win_factor = '0;
        w_grant      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_win == ID_W'(i)) begin
                w_win_color  = i_req_color[24*i +: 24];
                w_win_factor = i_req_factor[24*i +: 24];
                w_grant[i]   = w_found;
            end
        end
    end

`ifdef RGB_SCHED_WHITE_BYPASS_EN
    assign w_bypass = (w_win_factor == 24'hFFFFFF);
`else
    assign w_bypass = 1'b0;
`endif

    assign w_handshake = (r_state == S_IDLE) && w_found;
    assign w_capture   = i_mul_valid && (r_state == S_ISSUE || r_state == S_WAIT)
                         && (r_res_ch != 2'd3);

    always_comb begin
        case (r_issue_ch)
            2'd0:    begin w_chan_a = r_color[23:16]; w_chan_b = r_factor[23:16]; end
            2'd1:    begin w_chan_a = r_color[15:8];  w_chan_b = r_factor[15:8];  end
            default: begin w_chan_a = r_color[7:0];   w_chan_b = r_factor[7:0];   end
        endcase
    end

    always_comb begin
        w_res_next = r_res;
        if (w_capture) begin
            case (r_res_ch)
                2'd0:    w_res_next[23:16] = i_mul_result;
                2'd1:    w_res_next[15:8]  = i_mul_result;
                default: w_res_next[7:0]   = i_mul_result;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_found) w_next = w_bypass ? S_DONE : S_ISSUE;
            S_ISSUE: if (r_issue_ch == 2'd2) w_next = S_WAIT;
            S_WAIT:  if ((w_capture && r_res_ch == 2'd2) || r_res_ch == 2'd3) w_next = S_DONE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        o_req_ready  = (r_state == S_IDLE && !i_rst) ? w_grant : '0;
        o_mul_start  = (r_state == S_ISSUE);
        o_mul_a      = o_mul_start ? w_chan_a : r_mul_a;
        o_mul_b      = o_mul_start ? w_chan_b : r_mul_b;
        o_resp_valid = (r_state == S_DONE);
        o_resp_id    = r_resp_id;
        o_resp_color = r_resp_color;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ptr        <= ID_W'(NUM_REQ - 1);
            r_id         <= '0;
            r_color      <= '0;
            r_factor     <= '0;
            r_res        <= '0;
            r_issue_ch   <= '0;
            r_res_ch     <= '0;
            r_mul_a      <= '0;
            r_mul_b      <= '0;
            r_resp_id    <= '0;
            r_resp_color <= '0;
        end else begin
            if (w_handshake) begin
                r_ptr      <= w_win;
                r_id       <= w_win;
                r_color    <= w_win_color;
                r_factor   <= w_win_factor;
                r_res      <= '0;
                r_issue_ch <= '0;
                r_res_ch   <= '0;
                if (w_bypass) begin
                    r_resp_id    <= w_win;
                    r_resp_color <= w_win_color;
                end
            end
            if (r_state == S_ISSUE) begin
                r_issue_ch <= r_issue_ch + 2'd1;
                r_mul_a    <= w_chan_a;
                r_mul_b    <= w_chan_b;
            end
            if (w_capture) begin
                r_res    <= w_res_next;
                r_res_ch <= r_res_ch + 2'd1;
            end
            if (r_state == S_WAIT && w_next == S_DONE) begin
                r_resp_id    <= r_id;
                r_resp_color <= w_res_next;
            end
        end
    end

endmodule

// File: tb/tb_rgb_modulate_scheduler.sv
// Bench for rgb_modulate_scheduler: transaction-timing reference model, emulated multiplier
// with selectable latency, directed scenarios plus randomized request traffic.
module tb_rgb_modulate_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid, req_ready;
    logic [95:0] req_color, req_factor;
    logic        resp_valid;
    logic [1:0]  resp_id;
    logic [23:0] resp_color;
    logic        mul_start, mul_valid;
    logic [7:0]  mul_a, mul_b, mul_result;

    logic [23:0] col[4];
    logic [23:0] fac[4];
    assign req_color  = {col[3], col[2], col[1], col[0]};
    assign req_factor = {fac[3], fac[2], fac[1], fac[0]};

    always #5 clk = ~clk;

    rgb_modulate_scheduler #(.NUM_REQ(4)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_req_color(req_color), .i_req_factor(req_factor),
        .o_resp_valid(resp_valid), .o_resp_id(resp_id), .o_resp_color(resp_color),
        .o_mul_start(mul_start), .o_mul_a(mul_a), .o_mul_b(mul_b),
        .i_mul_result(mul_result), .i_mul_valid(mul_valid)
    );

`ifdef RGB_SCHED_WHITE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    int n_tests = 0, n_fail = 0;
    int cyc = 0, mul_lat = 1;

    typedef struct { int due; logic [7:0] r; } mq_t;
    mq_t mq[$];

    // reference model state
    bit          m_busy, m_byp;
    int          m_h, m_resp_cyc, m_ptr, m_win;
    logic [23:0] m_color, m_factor, m_rcol;
    logic [7:0]  m_last_a, m_last_b;
    int          m_rid;

    // observations used by directed checks
    int          last_grant_cyc, last_grant_idx, last_resp_cyc, last_resp_id, last_mv_cyc;
    logic [23:0] last_resp_color;
    int          start_cnt = 0;
    int          grant_idx_log[$], grant_cyc_log[$];

    function automatic logic [23:0] modulate(logic [23:0] c, logic [23:0] f);
        int r, g, b;
        r = (int'(c[23:16]) * int'(f[23:16])) >> 8;
        g = (int'(c[15:8])  * int'(f[15:8]))  >> 8;
        b = (int'(c[7:0])   * int'(f[7:0]))   >> 8;
        return {8'(r), 8'(g), 8'(b)};
    endfunction

    function automatic int rr_pick(logic [3:0] v, int ptr);
        for (int i = 1; i <= 4; i++)
            if (v[(ptr + i) % 4]) return (ptr + i) % 4;
        return -1;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d actual=%0h expected=%0h", nm, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_ptr = 3; m_rid = 0; m_rcol = '0; m_last_a = '0; m_last_b = '0;
    endtask

    task automatic check_cycle();
        logic [3:0]  e_ready;
        logic        e_start, e_rv;
        logic [7:0]  e_a, e_b;
        int          k, w;
        e_ready = '0; e_start = 0; e_rv = 0;
        if (rst) begin
            model_reset();
        end else begin
            if (m_busy && cyc > m_resp_cyc) m_busy = 0;
            if (m_busy && !m_byp && cyc >= m_h + 1 && cyc <= m_h + 3) begin
                k = cyc - m_h - 1;
                e_start  = 1;
                m_last_a = 8'(m_color  >> (16 - 8 * k));
                m_last_b = 8'(m_factor >> (16 - 8 * k));
            end
            if (m_busy && cyc == m_resp_cyc) begin
                e_rv   = 1;
                m_rid  = m_win;
                m_rcol = m_byp ? m_color : modulate(m_color, m_factor);
            end
            if (!m_busy) begin
                w = rr_pick(req_valid, m_ptr);
                if (w >= 0) begin
                    e_ready    = 4'(1 << w);
                    m_busy     = 1;
                    m_h        = cyc;
                    m_win      = w;
                    m_ptr      = w;
                    m_color    = col[w];
                    m_factor   = fac[w];
                    m_byp      = BYP && (fac[w] == 24'hFFFFFF);
                    m_resp_cyc = m_byp ? cyc + 1 : cyc + 4 + mul_lat;
                end
            end
        end
        e_a = m_last_a; e_b = m_last_b;
        chk("req_ready",  32'(req_ready),  32'(e_ready));
        chk("mul_start",  32'(mul_start),  32'(e_start));
        chk("mul_a",      32'(mul_a),      32'(e_a));
        chk("mul_b",      32'(mul_b),      32'(e_b));
        chk("resp_valid", 32'(resp_valid), 32'(e_rv));
        chk("resp_id",    32'(resp_id),    32'(m_rid));
        chk("resp_color", 32'(resp_color), 32'(m_rcol));

        for (int i = 0; i < 4; i++)
            if (req_ready[i]) begin
                last_grant_cyc = cyc; last_grant_idx = i;
                grant_idx_log.push_back(i); grant_cyc_log.push_back(cyc);
            end
        if (mul_start) begin
            start_cnt++;
            mq.push_back('{cyc + mul_lat, 8'((int'(mul_a) * int'(mul_b)) >> 8)});
        end
        if (resp_valid) begin
            last_resp_cyc = cyc; last_resp_id = resp_id; last_resp_color = resp_color;
        end
        if (mul_valid) last_mv_cyc = cyc;
    endtask

    task automatic drive_mul();
        int i;
        mul_valid = 0; mul_result = 8'($urandom);
        i = 0;
        while (i < mq.size()) begin
            if (mq[i].due == cyc) begin
                mul_valid = 1; mul_result = mq[i].r; mq.delete(i);
            end else i++;
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        #1;
        cyc++;
        drive_mul();
    endtask

    task automatic run_single(int idx, logic [23:0] c, logic [23:0] f,
                              output int off, output logic [23:0] rc,
                              output int rid, output int starts);
        int h, s0;
        col[idx] = c; fac[idx] = f;
        last_resp_cyc = -100; last_grant_cyc = -1; last_grant_idx = -1; s0 = start_cnt;
        req_valid = 4'(1 << idx);
        cycle();
        h = last_grant_cyc;
        chk("single_grant_idx", 32'(last_grant_idx), 32'(idx));
        req_valid = '0;
        repeat (10) cycle();
        off = last_resp_cyc - h; rc = last_resp_color; rid = last_resp_id;
        starts = start_cnt - s0;
    endtask

    initial begin
        int off, rid, starts;
        logic [23:0] rc;
        rst = 1; req_valid = '0; mul_valid = 0; mul_result = '0;
        for (int i = 0; i < 4; i++) begin col[i] = '0; fac[i] = '0; end
        model_reset();
        repeat (2) cycle();
        rst = 0;

        // all requesters pending: round-robin order from a fresh reset
        for (int i = 0; i < 4; i++) begin col[i] = 24'($urandom); fac[i] = 24'($urandom); end
        grant_idx_log.delete(); grant_cyc_log.delete();
        req_valid = 4'hF;
        repeat (26) cycle();
        req_valid = '0;
        repeat (8) cycle();
        chk("rr_grant_count", 32'(grant_idx_log.size()), 32'd5);
        for (int k = 0; k < 5; k++)
            if (k < grant_idx_log.size()) begin
                chk("rr_grant_order", 32'(grant_idx_log[k]), 32'(k % 4));
                if (k > 0) chk("rr_grant_spacing", 32'(grant_cyc_log[k] - grant_cyc_log[k-1]), 32'd6);
            end

        run_single(0, 24'h80FF40, 24'h808080, off, rc, rid, starts);
        chk("t1_latency", 32'(off), 32'd5);
        chk("t1_color",   32'(rc),  32'h407F20);
        chk("t1_id",      32'(rid), 32'd0);
        chk("t1_starts",  32'(starts), 32'd3);

        run_single(1, 24'hA5C37E, 24'h000000, off, rc, rid, starts);
        chk("t3_zero_color", 32'(rc), 32'h000000);
        chk("t3_zero_id",    32'(rid), 32'd1);

        run_single(2, 24'hFFFFFF, 24'hFFFFFF, off, rc, rid, starts);
        chk("t3_white_color",   32'(rc),  BYP ? 32'hFFFFFF : 32'hFEFEFE);
        chk("t3_white_latency", 32'(off), BYP ? 32'd1 : 32'd5);

        run_single(3, 24'h123456, 24'hFFFFFF, off, rc, rid, starts);
        chk("t5_color",   32'(rc),     BYP ? 32'h123456 : 32'h113355);
        chk("t5_latency", 32'(off),    BYP ? 32'd1 : 32'd5);
        chk("t5_starts",  32'(starts), BYP ? 32'd0 : 32'd3);
        chk("t5_id",      32'(rid),    32'd3);

        mul_lat = 3;
        run_single(0, 24'h80FF40, 24'h808080, off, rc, rid, starts);
        chk("t6_latency",      32'(off), 32'd7);
        chk("t6_color",        32'(rc),  32'h407F20);
        chk("t6_after_mv",     32'(last_resp_cyc - last_mv_cyc), 32'd1);

        // reset during the second ISSUE cycle; the stale result lands in IDLE after release
        col[2] = 24'($urandom); fac[2] = 24'($urandom) & 24'h7FFFFF;
        req_valid = 4'b0100;
        cycle();
        req_valid = '0;
        cycle();
        rst = 1; req_valid = 4'b0101;
        #1;
        chk("t4_rst_ready",  32'(req_ready),  32'd0);
        chk("t4_rst_start",  32'(mul_start),  32'd0);
        chk("t4_rst_a",      32'(mul_a),      32'd0);
        chk("t4_rst_b",      32'(mul_b),      32'd0);
        chk("t4_rst_rvalid", 32'(resp_valid), 32'd0);
        chk("t4_rst_id",     32'(resp_id),    32'd0);
        chk("t4_rst_color",  32'(resp_color), 32'd0);
        cycle();
        cycle();
        rst = 0;
        col[0] = 24'($urandom); fac[0] = 24'($urandom) & 24'h7FFFFF;
        grant_idx_log.delete();
        cycle();
        req_valid = 4'b0100;
        repeat (12) begin
            cycle();
            if (grant_idx_log.size() >= 2) req_valid = '0;
        end
        req_valid = '0;
        repeat (10) cycle();
        chk("t4_grant_count", 32'(grant_idx_log.size()), 32'd2);
        if (grant_idx_log.size() >= 2) begin
            chk("t4_first_req0", 32'(grant_idx_log[0]), 32'd0);
            chk("t4_then_req2",  32'(grant_idx_log[1]), 32'd2);
        end
        chk("t4_last_resp_id", 32'(last_resp_id), 32'd2);
        chk("t4_last_resp_color", 32'(last_resp_color), 32'(modulate(col[2], fac[2])));

        // randomized traffic at two multiplier latencies
        for (int lat = 1; lat <= 2; lat++) begin
            mul_lat = lat;
            repeat (300) begin
                req_valid = 4'($urandom_range(0, 15));
                for (int i = 0; i < 4; i++) begin
                    col[i] = 24'($urandom);
                    case ($urandom_range(0, 7))
                        0:       fac[i] = 24'hFFFFFF;
                        1:       fac[i] = 24'h000000;
                        default: fac[i] = 24'($urandom);
                    endcase
                end
                cycle();
            end
            req_valid = '0;
            repeat (10) cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
